pipe_mdu: RTL and testbench
===========================

PIPE_MDU -- requirements
Module: pipe_mdu

Interface
- REQ-001 SHALL have parameter WIDTH, 32, operand/HI/LO width (even, >=8).
- REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
- REQ-003 SHALL have port pcrst  input  1  reset, synchronous, active-high.
- REQ-004 SHALL have port start  input  1  request to issue op.
- REQ-005 SHALL have port op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- REQ-006 SHALL have ports a, b  input  WIDTH  operands (rs, rt).
- REQ-007 SHALL have port flush  input  1  abort in-flight op (branch/jump squash).
- REQ-008 SHALL have port rd_req  input  1  MFHI/MFLO in decode.
- REQ-009 SHALL have ports wr_hi, wr_lo  input  1  MTHI/MTLO strobes; wdata  input  WIDTH  write data.
- REQ-010 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.
- REQ-011 SHALL have port busy  output  1  op in flight.
- REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
- REQ-013 SHALL have port stall  output  1  pipeline hold request, combinational.

Function
- REQ-014 SHALL implement FSM states IDLE, RUN, FIX; IDLE->RUN on start&~flush; RUN->FIX after WIDTH iterations; FIX->IDLE unconditionally.
- REQ-015 SHALL, on accept edge, latch op, |a|,|b| (signed ops) or a,b, result signs, and clear iteration counter.
- REQ-016 SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle.
- REQ-017 SHALL, on FIX edge, apply sign correction, write HI/LO, and assert done for the following cycle only; new HI/LO visible WIDTH+1 cycles after accept edge.
- REQ-018 SHALL drive busy=1 in RUN and FIX, 0 in IDLE.
- REQ-019 SHALL produce multiply result {hi,lo} = full 2*WIDTH-bit product.
- REQ-020 SHALL produce divide lo=quotient truncated toward zero, hi=remainder with dividend's sign.
- REQ-021 SHALL on divide by zero give lo=all ones, hi=a (both DIV and DIVU).
- REQ-022 SHALL on DIV most-negative / -1 give lo=most-negative, hi=0.
- REQ-023 SHALL drive stall = busy & (start | rd_req | wr_hi | wr_lo).
- REQ-024 SHALL ignore start, wr_hi, wr_lo while busy.
- REQ-025 SHALL, in IDLE, write hi<=wdata on wr_hi and lo<=wdata on wr_lo; start in same cycle takes effect and later overwrites at FIX.
- REQ-026 SHALL on flush in RUN or FIX return to IDLE next edge, HI/LO unchanged, no done; flush with start in IDLE: flush wins, nothing accepted.

Reset
- REQ-027 SHALL on pcrst=1 at an edge force IDLE, hi=0, lo=0, busy=0, done=0, counter=0, overriding all other inputs including mid-operation.

Configuration
- REQ-028 SHALL support macro PIPE_MDU_DIV_EN: defined -> divide datapath built per REQ-020..022; undefined -> no divider logic, DIVU/DIV accepted in IDLE, busy stays 0, done pulses next cycle, HI/LO unchanged.

Structure
- REQ-029 SHALL take op encodings (MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV) and FSM state encodings from shared package mdu_pkg.
- REQ-030 SHALL place one iteration step (add/subtract, shift, quotient bit) in sub-module mdu_step; FSM, counter, sign logic and HI/LO stay in pipe_mdu.

Verification (WIDTH=32)
- REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 cycles after accept, hi=0xFFFFFFFE lo=0x00000001.
- REQ-032 MULT a=0xFFFFFFFD b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- REQ-033 DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- REQ-034 MTLO 0x1234 then MULT, flush at RUN cycle 10 -> busy=0 next cycle, no done, lo=0x1234.
- REQ-035 rd_req held during MULT -> stall=1 every busy cycle, 0 in done cycle; second start while busy ignored (one done only).
- REQ-036 pcrst asserted mid-DIV -> hi=lo=0, busy=0 next cycle, no done; build without PIPE_MDU_DIV_EN -> DIV yields done next cycle, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the pipelined multiply/divide unit.
//   mduOp_t    : operation encodings carried on the op port.
//   mduState_t : sequencer state encodings used by pipe_mdu.
//   isSignedOp : true for the two's-complement operations (MULT, DIV).
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mduOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mduState_t;

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step -- one combinational iteration of the iterative multiplier/divider.
//   isDiv   : 1 selects a restoring divide step, 0 a shift-add multiply step
//   accHi   : upper accumulator (partial product / partial remainder)
//   accLo   : lower accumulator (multiplier bits / dividend bits then quotient)
//   operand : multiplicand or divisor magnitude
//   nextHi, nextLo : accumulator values after this step
// The divide step exists only when PIPE_MDU_DIV_EN is defined.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0] sum;

`ifdef PIPE_MDU_DIV_EN
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
`else
    logic unusedIsDiv;
    assign unusedIsDiv = isDiv;
`endif

    always_comb begin
        // Multiply: conditionally add, then shift the {hi,lo} pair right one bit,
        // so multiplier bits leave accLo as product bits enter it.
        sum    = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        nextHi = sum[WIDTH:1];
        nextLo = {sum[0], accLo[WIDTH-1:1]};
`ifdef PIPE_MDU_DIV_EN
        // Restoring divide: bring in the next dividend bit; the remainder is
        // always below the divisor, so the difference fits in WIDTH bits.
        shifted = {accHi, accLo[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - operand;
        if (isDiv) begin
            if (shifted >= {1'b0, operand}) begin
                nextHi = diff;
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = shifted[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/pipe_mdu.sv
// pipe_mdu -- iterative MIPS-style HI/LO multiply/divide unit.
//   clk, pcrst        : clock, synchronous active-high reset
//   start, op, a, b   : issue MULTU/MULT/DIVU/DIV on operands a (rs), b (rt)
//   flush             : squash the in-flight operation
//   rd_req            : MFHI/MFLO waiting in decode
//   wr_hi, wr_lo,wdata: MTHI/MTLO writes (honoured only when idle)
//   hi, lo            : architectural HI/LO
//   busy, done, stall : in-flight flag, completion pulse, pipeline hold
// Macro PIPE_MDU_DIV_EN builds the divider; without it DIVU/DIV complete
// immediately and leave HI/LO untouched.
module pipe_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             pcrst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             rd_req,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mduState_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] accHi, accLo, operand;
    logic [WIDTH-1:0] stepHi, stepLo;
    logic [WIDTH-1:0] resHi, resLo;
    logic [WIDTH-1:0] magA, magB;
    logic             negA, negB, negQ;
    logic             opIsDiv, idleGo, accept, divNop, stepDiv;

`ifdef PIPE_MDU_DIV_EN
    logic divMode, negR, divZero;
`endif

    function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negIf2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        opIsDiv = (op == MDU_DIVU) || (op == MDU_DIV);
        negA    = isSignedOp(op) & a[WIDTH-1];
        negB    = isSignedOp(op) & b[WIDTH-1];
        magA    = negIf(a, negA);
        magB    = negIf(b, negB);
        idleGo  = (state == IDLE) && start && !flush;
`ifdef PIPE_MDU_DIV_EN
        accept  = idleGo;
        divNop  = 1'b0;
`else
        accept  = idleGo && !opIsDiv;
        divNop  = idleGo && opIsDiv;
`endif
    end

`ifdef PIPE_MDU_DIV_EN
    assign stepDiv = divMode;
`else
    assign stepDiv = 1'b0;
`endif

    mdu_step #(.WIDTH(WIDTH)) uStep (
        .isDiv   (stepDiv),
        .accHi   (accHi),
        .accLo   (accLo),
        .operand (operand),
        .nextHi  (stepHi),
        .nextLo  (stepLo)
    );

    // Sign correction applied at the FIX edge.
    always_comb begin
        {resHi, resLo} = negIf2({accHi, accLo}, negQ);
`ifdef PIPE_MDU_DIV_EN
        if (divMode) begin
            // Divide by zero leaves all-ones quotient bits and |a| as remainder;
            // restoring the dividend sign turns that remainder back into a.
            resLo = divZero ? '1 : negIf(accLo, negQ);
            resHi = negIf(accHi, negR);
        end
`endif
    end

    // Datapath registers: loaded on accept, advanced once per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            accHi   <= '0;
            accLo   <= magA;
            operand <= magB;
            negQ    <= negA ^ negB;
`ifdef PIPE_MDU_DIV_EN
            divMode <= opIsDiv;
            negR    <= negA;
            divZero <= (b == '0);
`endif
        end else if (state == RUN) begin
            accHi <= stepHi;
            accLo <= stepLo;
        end
    end

    // Sequencer and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (pcrst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (accept) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                    if (divNop) done <= 1'b1;
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi   <= resHi;
                        lo   <= resLo;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | rd_req | wr_hi | wr_lo);

endmodule

// File: tb/tb_pipe_mdu.sv
// tb_pipe_mdu -- self-checking bench for pipe_mdu (WIDTH=32) with directed
// corner cases and random operations against an arithmetic reference model.
module tb_pipe_mdu;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         pcrst, start, flush, rd_req, wr_hi, wr_lo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall;

    int           nChecks = 0;
    int           nFail = 0;
    logic [W-1:0] expHi = '0;
    logic [W-1:0] expLo = '0;

    always #5 clk = ~clk;

    pipe_mdu #(.WIDTH(W)) dut (
        .clk    (clk),
        .pcrst  (pcrst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .rd_req (rd_req),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (wdata),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: architectural results from plain arithmetic.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] p;
        case (o)
            2'b00: begin
                p = {32'b0, x} * {32'b0, y};
                expHi = p[63:32];
                expLo = p[31:0];
            end
            2'b01: begin
                p = 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
                expHi = p[63:32];
                expLo = p[31:0];
            end
            default: begin
`ifdef PIPE_MDU_DIV_EN
                if (y == '0) begin
                    expLo = '1;
                    expHi = x;
                end else if (o == 2'b10) begin
                    expLo = x / y;
                    expHi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    expLo = 32'h8000_0000;
                    expHi = '0;
                end else begin
                    expLo = 32'($signed(x) / $signed(y));
                    expHi = 32'($signed(x) % $signed(y));
                end
`endif
            end
        endcase
    endfunction

    // Cycles from accept edge to the cycle in which done is high.
    function automatic int expLat(input logic [1:0] o);
`ifdef PIPE_MDU_DIV_EN
        return W + 1;
`else
        return o[1] ? 0 : W + 1;
`endif
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        check({tag, ".busy1"}, 64'(busy), 64'(expLat(o) > 0));
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        model(o, x, y);
        check({tag, ".lat"}, 64'(lat), 64'(expLat(o)));
        check({tag, ".hi"}, 64'(hi), 64'(expHi));
        check({tag, ".lo"}, 64'(lo), 64'(expLo));
        check({tag, ".busyDone"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({tag, ".pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, bad, sawBusy, lat;
        pcrst = 1'b1; start = 1'b0; flush = 1'b0; rd_req = 1'b0;
        wr_hi = 1'b0; wr_lo = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst.hi", 64'(hi), 64'(0));
        check("rst.lo", 64'(lo), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        pcrst = 1'b0;

        runOp("multuMax", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multuMax.hiConst", 64'(hi), 64'hFFFF_FFFE);
        check("multuMax.loConst", 64'(lo), 64'h1);
        runOp("multNeg", MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        check("multNeg.loConst", 64'(lo), 64'hFFFF_FFEB);
        runOp("divNeg", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        runOp("divuZero", MDU_DIVU, 32'd5, 32'd0);
        runOp("divOvf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp("divZeroNeg", MDU_DIV, 32'hFFFF_FF00, 32'd0);

        // MTHI / MTLO in idle, then a squashed MULT.
        @(negedge clk); wr_lo = 1'b1; wdata = 32'h1234;
        @(negedge clk); wr_lo = 1'b0; wr_hi = 1'b1; wdata = 32'hABCD;
        @(negedge clk); wr_hi = 1'b0;
        expLo = 32'h1234; expHi = 32'hABCD;
        check("mtlo", 64'(lo), 64'(expLo));
        check("mthi", 64'(hi), 64'(expHi));
        start = 1'b1; op = MDU_MULT; a = 32'd1000; b = 32'hFFFF_FF00;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush.busy", 64'(busy), 64'(0));
        check("flush.done", 64'(done), 64'(0));
        check("flush.lo", 64'(lo), 64'(expLo));
        nd = 0;
        repeat (40) begin @(negedge clk); if (done) nd++; end
        check("flush.noDone", 64'(nd), 64'(0));
        check("flush.hi", 64'(hi), 64'(expHi));

        // Flush with start in idle: nothing accepted.
        start = 1'b1; flush = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd3;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        check("flushIdle.busy", 64'(busy), 64'(0));
        check("flushIdle.done", 64'(done), 64'(0));

        // Start and MTHI in the same idle cycle; MTLO while busy is ignored.
        start = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd5; wr_hi = 1'b1; wdata = 32'h5555;
        @(negedge clk); start = 1'b0; wr_hi = 1'b0;
        check("mthiStart.hi", 64'(hi), 64'h5555);
        check("mthiStart.busy", 64'(busy), 64'(1));
        @(negedge clk); wr_lo = 1'b1; wdata = 32'h7777;
        #1 check("mtloBusy.stall", 64'(stall), 64'(1));
        @(negedge clk); wr_lo = 1'b0;
        lat = 2;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        model(MDU_MULTU, 32'd3, 32'd5);
        check("mthiStart.lat", 64'(lat), 64'(W + 1));
        check("mthiStart.hiRes", 64'(hi), 64'(expHi));
        check("mtloBusy.lo", 64'(lo), 64'(expLo));

        // rd_req held across a MULTU; a second start while busy is ignored.
        @(negedge clk);
        rd_req = 1'b1; start = 1'b1; op = MDU_MULTU; a = 32'h0001_0001; b = 32'h0003_0003;
        @(negedge clk); start = 1'b0;
        nd = 0; bad = 0; sawBusy = 0;
        for (int c = 0; c <= 80; c++) begin
            if (busy) begin sawBusy++; if (!stall) bad++; end
            if (done) begin nd++; if (stall) bad++; end
            if (c == 5) begin start = 1'b1; op = MDU_MULT; a = 32'd7; b = 32'd9; end
            else start = 1'b0;
            @(negedge clk);
        end
        rd_req = 1'b0;
        model(MDU_MULTU, 32'h0001_0001, 32'h0003_0003);
        check("rdReq.stall", 64'(bad), 64'(0));
        check("rdReq.busyCycles", 64'(sawBusy), 64'(W + 1));
        check("rdReq.oneDone", 64'(nd), 64'(1));
        check("rdReq.hi", 64'(hi), 64'(expHi));
        check("rdReq.lo", 64'(lo), 64'(expLo));

        // Reset in the middle of an operation.
        start = 1'b1; a = 32'd100; b = 32'd7;
`ifdef PIPE_MDU_DIV_EN
        op = MDU_DIV;
`else
        op = MDU_MULT;
`endif
        @(negedge clk); start = 1'b0;
        repeat (11) @(negedge clk);
        pcrst = 1'b1;
        @(negedge clk); pcrst = 1'b0;
        expHi = '0; expLo = '0;
        check("midRst.hi", 64'(hi), 64'(0));
        check("midRst.lo", 64'(lo), 64'(0));
        check("midRst.busy", 64'(busy), 64'(0));
        nd = 0;
        repeat (40) begin if (done) nd++; @(negedge clk); end
        check("midRst.noDone", 64'(nd), 64'(0));

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            runOp($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), pickOperand(), pickOperand());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
